// File: rtl/rect_frame_ctl.sv
// Rectangle overlay on the VGA stream. The host writes geometry and colour into shadow registers,
// and a COMMIT copies them into the active set on the next vblank rising edge, so a frame never tears.
module rect_frame_ctl #(
  parameter logic [10:0] X_INIT   = 11'd100,
  parameter logic [10:0] Y_INIT   = 11'd100,
  parameter logic [10:0] W_INIT   = 11'd50,
  parameter logic [10:0] H_INIT   = 11'd50,
  parameter logic [11:0] RGB_INIT = 12'hA0A
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_addr,
  input  logic [11:0] cfg_data,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic [7:0]  commit_cnt
);

  typedef enum logic [0:0] {IDLE, ARMED} state_t;

  localparam logic [2:0] ADDR_X      = 3'd0;
  localparam logic [2:0] ADDR_Y      = 3'd1;
  localparam logic [2:0] ADDR_W      = 3'd2;
  localparam logic [2:0] ADDR_H      = 3'd3;
  localparam logic [2:0] ADDR_RGB    = 3'd4;
  localparam logic [2:0] ADDR_COMMIT = 3'd5;

  state_t      state_reg, state_next;
  logic        cfg_ready_reg;
  logic        vblnk_d_reg;
  logic        commit_now;
  logic        cfg_fire;
  logic        vblnk_rise;

  logic [10:0] sh_x_reg, sh_y_reg, sh_w_reg, sh_h_reg;
  logic [11:0] sh_rgb_reg;
  logic [10:0] act_x_reg, act_y_reg, act_w_reg, act_h_reg;
  logic [11:0] act_rgb_reg;
  logic [7:0]  commit_cnt_reg;

  logic [11:0] x_end, y_end;
  logic        hit;

  assign cfg_fire   = cfg_valid && cfg_ready_reg;
  assign vblnk_rise = vblnk_in && !vblnk_d_reg;

  always_comb begin
    state_next = state_reg;
    commit_now = 1'b0;
    case (state_reg)
      IDLE: begin
        // An edge coinciding with the COMMIT write is ignored: the commit waits for the next one.
        if (cfg_fire && (cfg_addr == ADDR_COMMIT)) state_next = ARMED;
      end
      ARMED: begin
        if (vblnk_rise) begin
          commit_now = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cfg_ready_reg <= 1'b0;
      vblnk_d_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cfg_ready_reg <= (state_next == IDLE);
      vblnk_d_reg   <= vblnk_in;
    end
  end

  // Shadow set: host-visible, written only while the controller is accepting writes.
  always_ff @(posedge pclk) begin
    if (rst) begin
      sh_x_reg   <= X_INIT;
      sh_y_reg   <= Y_INIT;
      sh_w_reg   <= W_INIT;
      sh_h_reg   <= H_INIT;
      sh_rgb_reg <= RGB_INIT;
    end else if (cfg_fire) begin
      case (cfg_addr)
        ADDR_X:   sh_x_reg   <= cfg_data[10:0];
        ADDR_Y:   sh_y_reg   <= cfg_data[10:0];
        ADDR_W:   sh_w_reg   <= cfg_data[10:0];
        ADDR_H:   sh_h_reg   <= cfg_data[10:0];
        ADDR_RGB: sh_rgb_reg <= cfg_data;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      act_x_reg      <= X_INIT;
      act_y_reg      <= Y_INIT;
      act_w_reg      <= W_INIT;
      act_h_reg      <= H_INIT;
      act_rgb_reg    <= RGB_INIT;
      commit_cnt_reg <= 8'd0;
    end else if (commit_now) begin
      act_x_reg      <= sh_x_reg;
      act_y_reg      <= sh_y_reg;
      act_w_reg      <= sh_w_reg;
      act_h_reg      <= sh_h_reg;
      act_rgb_reg    <= sh_rgb_reg;
      commit_cnt_reg <= commit_cnt_reg + 8'd1;
    end
  end

  // One extra bit keeps X+W and Y+H from wrapping near the top of the 11-bit range.
  assign x_end = {1'b0, act_x_reg} + {1'b0, act_w_reg};
  assign y_end = {1'b0, act_y_reg} + {1'b0, act_h_reg};

  always_comb begin
    hit = (act_w_reg != 11'd0) && (act_h_reg != 11'd0) &&
          (hcount_in >= act_x_reg) && ({1'b0, hcount_in} < x_end) &&
          (vcount_in >= act_y_reg) && ({1'b0, vcount_in} < y_end);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= 11'd0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vcount_out <= 11'd0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= 12'h000;
    end else begin
      hcount_out <= hcount_in;
      hsync_out  <= hsync_in;
      hblnk_out  <= hblnk_in;
      vcount_out <= vcount_in;
      vsync_out  <= vsync_in;
      vblnk_out  <= vblnk_in;
      rgb_out    <= (hblnk_in || vblnk_in) ? rgb_in : (hit ? act_rgb_reg : rgb_in);
    end
  end

  assign cfg_ready  = cfg_ready_reg;
  assign commit_cnt = commit_cnt_reg;

endmodule
